color_read_prefetch: RTL

// Upstream neighbour of the per-fragment stage. Accepts the in-order stream of framebuffer read requests
// (one per fragment) and issues reads to the on-chip colour RAM, which has a fixed read latency. It buffers
// the returned pixels and presents them on an rvalid/rready stream that feeds the per-fragment colour read port.
// It blocks read-after-write hazards: a request is held while an older fragment to the same index is still

---
 rtl/color_read_prefetch_if.sv | 29 ++
 rtl/color_read_prefetch.sv | 108 ++++++++++
 2 files changed

// File: rtl/color_read_prefetch_if.sv
// Bus bundle for the colour-read prefetcher: request stream, colour RAM read port,
// pixel stream towards the per-fragment stage and the write-back retire strobe.
interface color_read_prefetch_if #(
    parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
    parameter int PIXEL_WIDTH             = 32
);
    logic                               req_valid;
    logic                               req_ready;
    logic [FRAMEBUFFER_INDEX_WIDTH-1:0] req_index;
    logic                               mem_ren;
    logic [FRAMEBUFFER_INDEX_WIDTH-1:0] mem_raddr;
    logic [PIXEL_WIDTH-1:0]             mem_rdata;
    logic                               color_rvalid;
    logic                               color_rready;
    logic [PIXEL_WIDTH-1:0]             color_rdata;
    logic                               wb_valid;
    logic                               busy;
    logic                               err_underflow;

    modport slave (
        input  req_valid, req_index, mem_rdata, color_rready, wb_valid,
        output req_ready, mem_ren, mem_raddr, color_rvalid, color_rdata, busy, err_underflow
    );

    modport master (
        output req_valid, req_index, mem_rdata, color_rready, wb_valid,
        input  req_ready, mem_ren, mem_raddr, color_rvalid, color_rdata, busy, err_underflow
    );
endinterface

// File: rtl/color_read_prefetch.sv
// Issues in-order colour RAM reads, buffers returned pixels in a fall-through FIFO and
// holds any request whose index matches a fragment still awaiting write-back.
module color_read_prefetch #(
    parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
    parameter int PIXEL_WIDTH             = 32,
    parameter int READ_LATENCY            = 2,
    parameter int FIFO_DEPTH              = 8,
    parameter int INFLIGHT_DEPTH          = 8
) (
    input  logic                 aclk,
    input  logic                 reset,
    color_read_prefetch_if.slave bus
);
    localparam int FP_W = $clog2(FIFO_DEPTH);
    localparam int FC_W = FP_W + 1;
    localparam int IP_W = $clog2(INFLIGHT_DEPTH);
    localparam int IC_W = IP_W + 1;
    localparam logic [FC_W:0]   FIFO_LIMIT = (FC_W + 1)'(FIFO_DEPTH);
    localparam logic [IC_W-1:0] INFL_LIMIT = IC_W'(INFLIGHT_DEPTH);

    logic [PIXEL_WIDTH-1:0]             data_mem [FIFO_DEPTH];
    logic [FP_W-1:0]                    data_wr_ptr, data_rd_ptr;
    logic [FC_W-1:0]                    data_cnt, pend_cnt;
    logic [READ_LATENCY-1:0]            lat_sr;
    logic [FRAMEBUFFER_INDEX_WIDTH-1:0] infl_idx [INFLIGHT_DEPTH];
    logic [INFLIGHT_DEPTH-1:0]          infl_vld;
    logic [IP_W-1:0]                    infl_wr_ptr, infl_rd_ptr;
    logic [IC_W-1:0]                    inflight_cnt;
    logic                               mem_ren_q, err_q;
    logic [FRAMEBUFFER_INDEX_WIDTH-1:0] mem_raddr_q;
    logic                               hazard, ready, accept, data_push, data_pop, infl_pop;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < INFLIGHT_DEPTH; i++) begin
            if (infl_vld[i] && (infl_idx[i] == bus.req_index)) hazard = 1'b1;
        end
    end

    // Credit rule: reads already in RAM latency reserve their FIFO slot.
    assign ready     = !reset && !hazard && (inflight_cnt < INFL_LIMIT)
                       && (({1'b0, data_cnt} + {1'b0, pend_cnt}) < FIFO_LIMIT);
    assign accept    = bus.req_valid && ready;
    assign data_push = lat_sr[READ_LATENCY-1];
    assign data_pop  = (data_cnt != '0) && bus.color_rready;
    assign infl_pop  = bus.wb_valid && (inflight_cnt != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (reset) begin
            mem_ren_q   <= 1'b0;
            mem_raddr_q <= '0;
            lat_sr      <= '0;
            pend_cnt    <= '0;
            data_wr_ptr <= '0;
            data_rd_ptr <= '0;
            data_cnt    <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_ren_q <= accept;
            if (accept) mem_raddr_q <= bus.req_index;
            lat_sr <= (lat_sr << 1) | READ_LATENCY'(mem_ren_q);
            if (accept && !data_push)      pend_cnt <= pend_cnt + FC_W'(1);
            else if (!accept && data_push) pend_cnt <= pend_cnt - FC_W'(1);
            if (data_push) data_wr_ptr <= data_wr_ptr + FP_W'(1);
            if (data_pop)  data_rd_ptr <= data_rd_ptr + FP_W'(1);
            if (data_push && !data_pop)      data_cnt <= data_cnt + FC_W'(1);
            else if (!data_push && data_pop) data_cnt <= data_cnt - FC_W'(1);
            if (bus.wb_valid && (inflight_cnt == '0)) err_q <= 1'b1;
        end
    end

    // NOTE: storage arrays carry no reset; counters and valid bits decide what is meaningful.
    always_ff @(posedge aclk) begin
        if (data_push) data_mem[data_wr_ptr] <= bus.mem_rdata;
        if (accept)    infl_idx[infl_wr_ptr] <= bus.req_index;
    end

    // Write-backs retire in request order, so the in-flight list is a plain FIFO.
    always_ff @(posedge aclk) begin
        if (reset) begin
            infl_vld     <= '0;
            infl_wr_ptr  <= '0;
            infl_rd_ptr  <= '0;
            inflight_cnt <= '0;
        end else begin
            if (accept) begin
                infl_vld[infl_wr_ptr] <= 1'b1;
                infl_wr_ptr           <= infl_wr_ptr + IP_W'(1);
            end
            if (infl_pop) begin
                infl_vld[infl_rd_ptr] <= 1'b0;
                infl_rd_ptr           <= infl_rd_ptr + IP_W'(1);
            end
            if (accept && !infl_pop)      inflight_cnt <= inflight_cnt + IC_W'(1);
            else if (!accept && infl_pop) inflight_cnt <= inflight_cnt - IC_W'(1);
        end
    end

    assign bus.req_ready     = ready;
    assign bus.mem_ren       = mem_ren_q;
    assign bus.mem_raddr     = mem_raddr_q;
    assign bus.color_rvalid  = (data_cnt != '0);
    assign bus.color_rdata   = (data_cnt != '0) ? data_mem[data_rd_ptr] : '0;
    assign bus.busy          = (inflight_cnt != '0);
    assign bus.err_underflow = err_q;
endmodule
